mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Multiply/divide unit in the EX stage, directly upstream of the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU from the pipeline.
- Computes the 64-bit product in one registered cycle. Computes quotient/remainder with a 32-iteration restoring divider.
- Presents hi/lo with a one-cycle write-enable pulse to the HI/LO register. Stalls the pipeline while an operation is in flight.

Parameters:
WIDTH, 32, operand width; hi/lo width. Only 32 is supported; iteration count equals WIDTH.

Ports:
cpu_clk_75M  in  1  CPU clock; all state updates on its rising edge
cpu_rst  in  1  synchronous, active-high reset
start_i  in  1  request a new operation; sampled only in IDLE
op_i  in  2  operation select: MULT, MULTU, DIV, DIVU (package constants)
src_a_i  in  32  rs operand (multiplicand / dividend)
src_b_i  in  32  rt operand (multiplier / divisor)
annul_i  in  1  flush: abandon the in-flight operation, no HI/LO write
stall_o  out  1  pipeline stall request
hilo_we_o  out  1  one-cycle write strobe to HI/LO
hi_o  out  32  HI result (product[63:32] / remainder)
lo_o  out  32  LO result (product[31:0] / quotient)

Behaviour:
- Reset: cpu_rst sampled high puts state in IDLE and clears the counter, hi_o, lo_o, hilo_we_o and internal operand registers to 0. Reset wins over every other input, including mid-operation. No write is produced for an aborted operation.
- States and transitions:
  - IDLE: start_i=1 and annul_i=0 → MUL (MULT/MULTU) or DIV (DIV/DIVU). Operands are latched on that edge.
  - MUL: one cycle; the signed or unsigned 64-bit product is registered into hi/lo → DONE.
  - DIV: 32 cycles. Restoring shift-subtract on operand magnitudes; counter counts 0..31. On the last iteration the sign-corrected quotient and remainder are registered → DONE.
  - DONE: hilo_we_o=1 for exactly this cycle → IDLE.
- Latency, with start accepted in cycle T:
  - MULT/MULTU: hilo_we_o high in cycle T+2.
  - DIV/DIVU: hilo_we_o high in cycle T+33.
- stall_o:
  - Combinational: high when (IDLE and start_i and not annul_i), or when state is MUL or DIV.
  - Low in DONE, so the requesting instruction advances as the result is written.
- start_i outside IDLE is ignored (stall_o holds the requester).
- hi_o/lo_o hold their last value after DONE until the next result is registered.
- Signed arithmetic:
  - MULT: two's-complement 32x32→64.
  - DIV: quotient negative iff the operand signs differ. Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - Unsigned ops use operands as-is.
- Divide by zero: no trap; full 32-cycle latency. Result is lo=0xFFFFFFFF, hi=dividend (raw src_a, no sign correction) for both DIV and DIVU.
- Annul:
  - annul_i in MUL or DIV returns to IDLE next edge. No hilo_we_o; hi_o/lo_o keep their pre-operation values.
  - annul_i in DONE forces hilo_we_o low that cycle; the state still returns to IDLE.
  - annul_i together with start_i in IDLE: the request is not accepted.
- Back-to-back: a new start_i is accepted in the IDLE cycle following DONE, at the earliest.

Decomposition:
- Shared package: op encodings (OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11), state enum (IDLE, MUL, DIV, DONE), and the divide-by-zero LO constant.
- One sub-module, div_core: the 32-cycle restoring divider with its counter.
  - Inputs: start, abort, unsigned magnitudes.
  - Outputs: magnitude quotient/remainder plus a done pulse.
  - Sign handling, the multiplier and the FSM stay in mdu_iter.

Test Plan:
- MULT, a=0xFFFFFFFD (-3), b=5, start at T → stall_o high T..T+1, low T+2. hilo_we_o=1 only at T+2 with hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU, a=b=0xFFFFFFFF → at T+2 hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands gives hi=0, lo=1.
- DIVU 100/7 → hilo_we_o at T+33 only, lo=14, hi=2. DIV 0xFFFFFFF9 (-7) / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x1234/0 → T+33: lo=0xFFFFFFFF, hi=0x00001234, no other side effect.
- DIV started at T with annul_i pulsed at T+10 → state IDLE at T+11, no hilo_we_o through T+40. hi/lo unchanged; the next MULT completes normally.
- cpu_rst asserted at T+5 of a DIV → next cycle all outputs 0 and IDLE, no write. start_i during DIV's stall cycles is ignored; exactly one write occurs.

Source files
------------

// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// the divide-by-zero LO value and small sign helpers.
package mdu_iter_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [XLEN-1:0] DIV_ZERO_LO = '1;

  function automatic logic is_signed_op(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Two's-complement magnitude; the most negative value maps onto itself, which
  // is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(logic [XLEN-1:0] v, logic sgn);
    return (sgn && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_core.sv
// Restoring shift-subtract divider on unsigned magnitudes: WIDTH iterations,
// one per cycle, with a done pulse during the final iteration.
module div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;

  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             last;

  // Partial remainder stays below the divisor, so WIDTH+2 bits hold the shifted
  // trial value plus a clean borrow bit.
  always_comb begin
    trial    = {1'b0, rem_q, quo_q[WIDTH-1]} - {2'b00, dsr_q};
    fits     = ~trial[WIDTH+1];
    rem_step = fits ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
    quo_step = {quo_q[WIDTH-2:0], fits};
    last     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  end

  // NOTE: every always_comb output gets a default before any branch, otherwise
  // an unassigned path infers a latch.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dsr_d  = dsr_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      rem_d  = '0;
      quo_d  = dividend;
      dsr_d  = divisor;
    end else if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (busy_q) begin
      rem_d = rem_step;
      quo_d = quo_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) busy_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dsr_q  <= dsr_d;
    end
  end

  assign quotient  = quo_step;
  assign remainder = rem_step;
  assign done      = last;

endmodule

// File: rtl/mdu_iter.sv
// EX-stage multiply/divide unit feeding the HI/LO pair: single-cycle registered
// product, 32-cycle restoring divide, one-cycle write strobe, pipeline stall.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             cpu_clk_75M,
  input  logic             cpu_rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             annul_i,
  output logic             stall_o,
  output logic             hilo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  op_e              op_in;
  logic             sgn_in;
  logic             accept;
  logic             div_start;
  logic             div_abort;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic             div_done;

  logic               sgn_q;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  logic               q_neg, r_neg, div_by_zero;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_in     = op_e'(op_i);
  assign sgn_in    = is_signed_op(op_in);
  assign accept    = (state_q == IDLE) && start_i && !annul_i;
  assign div_start = accept && is_div_op(op_in);
  assign div_abort = (state_q == DIV) && annul_i;
  assign mag_a     = abs_val(src_a_i, sgn_in);
  assign mag_b     = abs_val(src_b_i, sgn_in);

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (cpu_clk_75M),
    .rst       (cpu_rst),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Sign-extending to 2*WIDTH lets one truncated multiply serve both MULT and MULTU.
  assign sgn_q   = is_signed_op(op_q);
  assign ext_a   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign ext_b   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign product = ext_a * ext_b;

  assign q_neg       = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign r_neg       = sgn_q & a_q[WIDTH-1];
  assign div_by_zero = (b_q == '0);
  assign quo_fix     = q_neg ? -div_quo : div_quo;
  assign rem_fix     = r_neg ? -div_rem : div_rem;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_o   = 1'b0;
    hilo_we_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          stall_o = 1'b1;
          op_d    = op_in;
          a_d     = src_a_i;
          b_d     = src_b_i;
          state_d = is_div_op(op_in) ? DIV : MUL;
        end
      end
      MUL: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          hi_d    = product[2*WIDTH-1:WIDTH];
          lo_d    = product[WIDTH-1:0];
          state_d = DONE;
        end
      end
      DIV: begin
        stall_o = 1'b1;
        if (annul_i) begin
          state_d = IDLE;
        end else if (div_done) begin
          // Divide by zero reports the raw dividend, not the magnitude.
          hi_d    = div_by_zero ? a_q : rem_fix;
          lo_d    = div_by_zero ? DIV_ZERO_LO : quo_fix;
          state_d = DONE;
        end
      end
      DONE: begin
        hilo_we_o = !annul_i;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_75M) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: expected HI/LO and write cycle are queued at
// issue time and compared whenever the DUT strobes hilo_we_o.
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        cpu_clk_75M;
  logic        cpu_rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        annul_i;
  logic        stall_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  mdu_iter #(.WIDTH(32)) dut (
    .cpu_clk_75M (cpu_clk_75M),
    .cpu_rst     (cpu_rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .src_a_i     (src_a_i),
    .src_b_i     (src_b_i),
    .annul_i     (annul_i),
    .stall_o     (stall_o),
    .hilo_we_o   (hilo_we_o),
    .hi_o        (hi_o),
    .lo_o        (lo_o)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          n_writes    = 0;
  logic [31:0] last_hi     = '0;
  logic [31:0] last_lo     = '0;
  exp_t        mon_e;

  initial cpu_clk_75M = 1'b0;
  always #7 cpu_clk_75M = ~cpu_clk_75M;

  always @(posedge cpu_clk_75M) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(op_e op, logic [31:0] a, logic [31:0] b);
    longint      sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    p   = '0;
    case (op)
      OP_MULT:  p = sa * sbv;
      OP_MULTU: p = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Scoreboard side: every write must match the oldest pending expectation.
  always @(negedge cpu_clk_75M) begin
    if (hilo_we_o) begin
      n_writes++;
      if (sb.size() == 0) begin
        check("unexpected_write", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("write_cycle", 64'(cyc), 64'(mon_e.due));
        check("hi", {32'h0, hi_o}, {32'h0, mon_e.hi});
        check("lo", {32'h0, lo_o}, {32'h0, mon_e.lo});
        last_hi = mon_e.hi;
        last_lo = mon_e.lo;
      end
    end
  end

  task automatic step();
    @(posedge cpu_clk_75M);
    #1;
  endtask

  // Presents a request in the current cycle; optionally queues its expected result.
  task automatic drive(input op_e op, input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t        e;
    logic [63:0] p;
    start_i = 1'b1;
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    if (push) begin
      p     = model(op, a, b);
      e.hi  = p[63:32];
      e.lo  = p[31:0];
      e.due = cyc + (is_div_op(op) ? 33 : 2);
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  task automatic run_op(input op_e op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b, 1'b1);
    step();
    start_i = 1'b0;
    drain();
  endtask

  initial begin
    int t0;
    int w0;
    cpu_rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    op_i    = 2'b00;
    src_a_i = '0;
    src_b_i = '0;
    step();
    step();
    check("rst_hi", {32'h0, hi_o}, 64'd0);
    check("rst_lo", {32'h0, lo_o}, 64'd0);
    check("rst_we", {63'h0, hilo_we_o}, 64'd0);
    check("rst_stall", {63'h0, stall_o}, 64'd0);
    cpu_rst = 1'b0;
    step();

    // MULT -3 * 5 with stall profile.
    drive(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1);
    @(negedge cpu_clk_75M);
    check("mult_stall_T", {63'h0, stall_o}, 64'd1);
    step();
    start_i = 1'b0;
    @(negedge cpu_clk_75M);
    check("mult_stall_T1", {63'h0, stall_o}, 64'd1);
    check("mult_we_T1", {63'h0, hilo_we_o}, 64'd0);
    step();
    @(negedge cpu_clk_75M);
    check("mult_stall_T2", {63'h0, stall_o}, 64'd0);
    check("mult_we_T2", {63'h0, hilo_we_o}, 64'd1);
    drain();

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_DIVU,  32'd100, 32'd7);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIVU,  32'h0000_1234, 32'd0);
    run_op(OP_DIV,   32'hFFFF_FFF0, 32'd0);
    run_op(OP_DIV,   32'd9, 32'hFFFF_FFFC);
    run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000);

    // Annul mid-divide: no write, HI/LO untouched, then a normal MULT.
    drive(OP_DIV, 32'd1000, 32'd3, 1'b0);
    t0 = cyc;
    step();
    start_i = 1'b0;
    while (cyc < t0 + 10) step();
    annul_i = 1'b1;
    step();
    annul_i = 1'b0;
    @(negedge cpu_clk_75M);
    check("annul_idle_stall", {63'h0, stall_o}, 64'd0);
    while (cyc < t0 + 40) step();
    check("annul_hi_kept", {32'h0, hi_o}, {32'h0, last_hi});
    check("annul_lo_kept", {32'h0, lo_o}, {32'h0, last_lo});
    run_op(OP_MULT, 32'd12345, 32'hFFFF_FF00);

    // Annul in DONE suppresses the strobe.
    drive(OP_MULTU, 32'd7, 32'd6, 1'b0);
    step();
    start_i = 1'b0;
    step();
    annul_i = 1'b1;
    @(negedge cpu_clk_75M);
    check("annul_done_we", {63'h0, hilo_we_o}, 64'd0);
    check("annul_done_stall", {63'h0, stall_o}, 64'd0);
    step();
    annul_i = 1'b0;

    // Annul alongside start in IDLE: request refused.
    drive(OP_MULT, 32'd3, 32'd3, 1'b0);
    annul_i = 1'b1;
    @(negedge cpu_clk_75M);
    check("annul_start_stall", {63'h0, stall_o}, 64'd0);
    step();
    start_i = 1'b0;
    annul_i = 1'b0;
    repeat (4) step();

    // Reset in the middle of a divide.
    drive(OP_DIV, 32'hFFFF_0000, 32'd17, 1'b0);
    t0 = cyc;
    step();
    start_i = 1'b0;
    while (cyc < t0 + 5) step();
    cpu_rst = 1'b1;
    step();
    cpu_rst = 1'b0;
    @(negedge cpu_clk_75M);
    check("midrst_hi", {32'h0, hi_o}, 64'd0);
    check("midrst_lo", {32'h0, lo_o}, 64'd0);
    check("midrst_we", {63'h0, hilo_we_o}, 64'd0);
    check("midrst_stall", {63'h0, stall_o}, 64'd0);
    repeat (40) step();
    check("midrst_hi_hold", {32'h0, hi_o}, 64'd0);

    // start_i held during the divide's stall cycles is ignored.
    w0 = n_writes;
    drive(OP_DIVU, 32'd1000, 32'd3, 1'b1);
    step();
    op_i    = OP_MULT;
    src_a_i = 32'd11;
    src_b_i = 32'd13;
    repeat (15) step();
    start_i = 1'b0;
    drain();
    repeat (5) step();
    check("single_write", 64'(n_writes - w0), 64'd1);

    // Random mix, issued back-to-back.
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom();
      rb = (i % 4 == 3) ? 32'd0 : $urandom();
      run_op(op_e'($urandom_range(0, 3)), ra, rb);
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
